// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer and later board-input labs:
// FSM state encoding and the default stability window.
package debounce_pkg;

  localparam logic [1:0] ST_LOW      = 2'b00;
  localparam logic [1:0] ST_LOW_PEND = 2'b01;
  localparam logic [1:0] ST_HIGH     = 2'b10;
  localparam logic [1:0] ST_HIGH_PEND = 2'b11;

  // 1 ms at a 50 MHz system clock.
  localparam int DEFAULT_STABLE_COUNT = 50000;

  typedef enum logic [1:0] {
    S_LOW       = ST_LOW,
    S_LOW_PEND  = ST_LOW_PEND,
    S_HIGH      = ST_HIGH,
    S_HIGH_PEND = ST_HIGH_PEND
  } state_t;

endpackage

// File: rtl/switch_debouncer_sync2.sv
// Two-flop synchronizer for a single asynchronous board input; resets to 0.
// Reused by later labs for other switches and buttons.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic sync1;

  // NOTE: sequential state uses non-blocking assignments so both flops
  // sample their inputs from the same edge and form a real two-stage chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      q     <= 1'b0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a raw switch: synchronizes it, requires STABLE_COUNT consecutive
// differing samples before the level F flips, and emits one-cycle rise/fall pulses.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT,
  parameter int CNT_WIDTH    = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic A,
  output logic F,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  // A window of one cycle needs no pending state: flip on the first differing sample.
  localparam bit DIRECT = (STABLE_COUNT == 1);

  logic                 s;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;

  sync2 u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d     (A),
    .q     (s)
  );

  // NOTE: every register, including the counter, is cleared by reset so an
  // in-flight pend is aborted and no stale count survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_LOW;
      cnt   <= '0;
      F     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        S_LOW: begin
          if (s && DIRECT) begin
            state <= S_HIGH;
            F     <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else if (s) begin
            state <= S_LOW_PEND;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        S_LOW_PEND: begin
          if (!s) begin
            state <= S_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= S_HIGH;
            F     <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!s && DIRECT) begin
            state <= S_LOW;
            F     <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
          end else if (!s) begin
            state <= S_HIGH_PEND;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        S_HIGH_PEND: begin
          if (s) begin
            state <= S_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= S_LOW;
            F     <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
